// File: rtl/vfd_tspi_rx.sv
`default_nettype none
// ============================================================================
// Module   : vfd_tspi_rx
// Purpose  : Tri-SPI loopback receiver for the MN15439A VFD link. It
//            deserializes S1..S3/SCK/LAT/BLK into 6-bit pixel words, the
//            active grid position and per-frame length/grid error flags.
// Revision : 1.0 - initial release
// ============================================================================
module vfd_tspi_rx #(
  parameter int PIX_CYCLES   = 234,
  parameter int FRAME_CYCLES = 288,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCK_IN,
  input  logic [2:0] S_IN,
  input  logic       LAT_IN,
  input  logic       BLK_IN,
  output logic [5:0] PIX_WORD,
  output logic [6:0] PIX_IDX,
  output logic       PIX_VALID,
  output logic [5:0] GRID_POS,
  output logic       FRAME_DONE,
  output logic [8:0] BIT_CNT,
  output logic       LEN_ERR,
  output logic       GRID_ERR
);

  localparam logic [8:0] c_pix_cycles   = 9'(PIX_CYCLES);
  localparam logic [8:0] c_pix_last     = 9'(PIX_CYCLES - 1);
  localparam logic [8:0] c_frame_cycles = 9'(FRAME_CYCLES);
  localparam logic [8:0] c_frame_last   = 9'(FRAME_CYCLES - 1);
  localparam logic [8:0] c_cnt_max      = 9'd511;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PIX  = 2'd1,
    ST_GRID = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // All link pins share one packed chain so every bit sees the same delay:
  // {BLK, LAT, S[2:0], SCK}
  logic [SYNC_STAGES-1:0][5:0] r_sync;
  logic [5:0]                  w_synced;
  logic                        r_sck_prev;
  logic                        r_lat_prev;
  logic                        w_sck_edge;
  logic                        w_lat_edge;
  logic [2:0]                  w_s;

  state_t     r_state, w_state_nxt, w_eff_state;

  logic [8:0] r_cnt, w_cnt_nxt, w_eff_cnt;
  logic [2:0] r_hold, w_hold_nxt, w_eff_hold;
  logic       r_in_run, w_in_run_nxt, w_eff_in_run;
  logic [1:0] r_run_cnt, w_run_cnt_nxt, w_eff_run_cnt;
  logic [5:0] r_run_len, w_run_len_nxt, w_eff_run_len;
  logic       r_grid_bad, w_grid_bad_nxt, w_eff_grid_bad;
  logic [5:0] w_grid_ofs;

  logic [5:0] r_pix_word, w_pix_word_nxt;
  logic [6:0] r_pix_idx, w_pix_idx_nxt;
  logic       r_pix_valid, w_pix_valid_nxt;
  logic [5:0] r_grid_pos, w_grid_pos_nxt;
  logic       r_frame_done, w_frame_done_nxt;
  logic [8:0] r_bit_cnt, w_bit_cnt_nxt;
  logic       r_len_err, w_len_err_nxt;
  logic       r_grid_err, w_grid_err_nxt;

  // Input synchronizer chain plus previous-value flops for edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync     <= '0;
      r_sck_prev <= 1'b0;
      r_lat_prev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], {BLK_IN, LAT_IN, S_IN, SCK_IN}};
      r_sck_prev <= w_synced[0];
      r_lat_prev <= w_synced[4];
    end
  end

  assign w_synced   = r_sync[SYNC_STAGES-1];
  assign w_s        = w_synced[3:1];
  assign w_sck_edge = w_synced[0] & ~r_sck_prev & ~w_synced[5];
  assign w_lat_edge = w_synced[4] & ~r_lat_prev;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update; a LAT edge first resets the frame
  // context, then any coincident SCK edge is applied as edge 0 of it
  always_comb begin
    w_eff_state    = r_state;
    w_eff_cnt      = r_cnt;
    w_eff_hold     = r_hold;
    w_eff_in_run   = r_in_run;
    w_eff_run_cnt  = r_run_cnt;
    w_eff_run_len  = r_run_len;
    w_eff_grid_bad = r_grid_bad;

    w_frame_done_nxt = 1'b0;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_len_err_nxt    = r_len_err;
    w_grid_err_nxt   = r_grid_err;

    if (w_lat_edge) begin
      if (r_state != ST_IDLE) begin
        w_frame_done_nxt = 1'b1;
        w_bit_cnt_nxt    = r_cnt;
        w_len_err_nxt    = (r_cnt != c_frame_cycles);
        w_grid_err_nxt   = r_grid_bad | (r_run_cnt != 2'd1) | (r_run_len != 6'd2);
      end
      w_eff_state    = ST_PIX;
      w_eff_cnt      = '0;
      w_eff_hold     = '0;
      w_eff_in_run   = 1'b0;
      w_eff_run_cnt  = '0;
      w_eff_run_len  = '0;
      w_eff_grid_bad = 1'b0;
    end

    w_state_nxt     = w_eff_state;
    w_cnt_nxt       = w_eff_cnt;
    w_hold_nxt      = w_eff_hold;
    w_in_run_nxt    = w_eff_in_run;
    w_run_cnt_nxt   = w_eff_run_cnt;
    w_run_len_nxt   = w_eff_run_len;
    w_grid_bad_nxt  = w_eff_grid_bad;
    w_pix_word_nxt  = r_pix_word;
    w_pix_idx_nxt   = r_pix_idx;
    w_pix_valid_nxt = 1'b0;
    w_grid_pos_nxt  = r_grid_pos;
    w_grid_ofs      = 6'(w_eff_cnt - c_pix_cycles);

    if (w_sck_edge && (w_eff_state != ST_IDLE)) begin
      w_cnt_nxt = (w_eff_cnt == c_cnt_max) ? c_cnt_max : w_eff_cnt + 9'd1;
      case (w_eff_state)
        ST_PIX: begin
          if (!w_eff_cnt[0]) begin
            w_hold_nxt = w_s;
          end else begin
            w_pix_word_nxt  = {w_eff_hold, w_s};
            w_pix_idx_nxt   = 7'(w_eff_cnt >> 1);
            w_pix_valid_nxt = 1'b1;
          end
          if (w_eff_cnt == c_pix_last) begin
            w_state_nxt = ST_GRID;
          end
        end
        ST_GRID: begin
          case (w_s)
            3'b111: begin
              if (!w_eff_in_run) begin
                w_in_run_nxt  = 1'b1;
                w_run_len_nxt = 6'd1;
                if (w_eff_run_cnt == 2'd0) begin
                  w_grid_pos_nxt = w_grid_ofs;
                end
                if (w_eff_run_cnt != 2'd3) begin
                  w_run_cnt_nxt = w_eff_run_cnt + 2'd1;
                end
              end else if (w_eff_run_len != 6'd63) begin
                w_run_len_nxt = w_eff_run_len + 6'd1;
              end
            end
            3'b000:  w_in_run_nxt   = 1'b0;
            default: w_grid_bad_nxt = 1'b1;
          endcase
          if (w_eff_cnt == c_frame_last) begin
            w_state_nxt = ST_HOLD;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt        <= '0;
      r_hold       <= '0;
      r_in_run     <= 1'b0;
      r_run_cnt    <= '0;
      r_run_len    <= '0;
      r_grid_bad   <= 1'b0;
      r_pix_word   <= '0;
      r_pix_idx    <= '0;
      r_pix_valid  <= 1'b0;
      r_grid_pos   <= '0;
      r_frame_done <= 1'b0;
      r_bit_cnt    <= '0;
      r_len_err    <= 1'b0;
      r_grid_err   <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_hold       <= w_hold_nxt;
      r_in_run     <= w_in_run_nxt;
      r_run_cnt    <= w_run_cnt_nxt;
      r_run_len    <= w_run_len_nxt;
      r_grid_bad   <= w_grid_bad_nxt;
      r_pix_word   <= w_pix_word_nxt;
      r_pix_idx    <= w_pix_idx_nxt;
      r_pix_valid  <= w_pix_valid_nxt;
      r_grid_pos   <= w_grid_pos_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_len_err    <= w_len_err_nxt;
      r_grid_err   <= w_grid_err_nxt;
    end
  end

  assign PIX_WORD   = r_pix_word;
  assign PIX_IDX    = r_pix_idx;
  assign PIX_VALID  = r_pix_valid;
  assign GRID_POS   = r_grid_pos;
  assign FRAME_DONE = r_frame_done;
  assign BIT_CNT    = r_bit_cnt;
  assign LEN_ERR    = r_len_err;
  assign GRID_ERR   = r_grid_err;

endmodule
`default_nettype wire
